// File: rtl/serial_mux_reducer.sv
// Bit-serial reduction stage: scans a captured word LSB-first, one bit per cycle,
// folding each bit into a mux-built accumulator, and reports the reduction plus a popcount.
`timescale 1ns/1ps

module serial_mux_reducer #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_result,
  output logic [CNT_W-1:0] out_count
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_t;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] data_q,      data_d;
  op_t              op_q,        op_d;
  logic [IDX_W-1:0] idx_q,       idx_d;
  logic             acc_q,       acc_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             result_q,    result_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic cur_bit;
  logic step_acc;

  assign cur_bit = data_q[idx_q];

  // Each step is a 2:1 selection between the accumulator-derived value and the bit.
  always_comb begin
    step_acc = acc_q;
    case (op_q)
      OP_AND:  step_acc = acc_q ? cur_bit : 1'b0;
      OP_XOR:  step_acc = cur_bit ? ~acc_q : acc_q;
      default: step_acc = acc_q ? 1'b1 : cur_bit;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    op_d        = op_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    count_d     = count_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d     = in_data;
          op_d       = op_t'(in_op);
          idx_d      = '0;
          cnt_d      = '0;
          acc_d      = (op_t'(in_op) == OP_AND);
          state_d    = S_BUSY;
          in_ready_d = 1'b0;
        end
      end
      S_BUSY: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CNT_W'(cur_bit);
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          idx_d       = '0;
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          result_d    = (op_q == OP_NOR) ? ~step_acc : step_acc;
          count_d     = cnt_q + CNT_W'(cur_bit);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // Handshake flags are registered alongside the state so they never depend on inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      op_q        <= OP_OR;
      idx_q       <= '0;
      acc_q       <= 1'b0;
      cnt_q       <= '0;
      result_q    <= 1'b0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_count  = count_q;

  a_hold_under_backpressure: assert property (
    @(posedge clk) disable iff (!rst_n)
    (out_valid_q && !out_ready) |=> (out_valid_q && $stable(result_q) && $stable(count_q))
  );

  a_count_bounded: assert property (
    @(posedge clk) disable iff (!rst_n) count_q <= CNT_W'(WIDTH)
  );

  a_flags_exclusive: assert property (
    @(posedge clk) disable iff (!rst_n) !(in_ready_q && out_valid_q)
  );

endmodule

// File: tb/tb_serial_mux_reducer.sv
// Scoreboard bench for serial_mux_reducer: expected results are queued at stimulus
// time from a reference model and popped when the block presents its output.
`timescale 1ns/1ps

module tb_serial_mux_reducer;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [1:0]       in_op = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_result;
  logic [CNT_W-1:0] out_count;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic             res;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];

  serial_mux_reducer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_count  (out_count)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [WIDTH-1:0] d, input logic [1:0] op);
    exp_t e;
    case (op)
      2'b00:   e.res = |d;
      2'b01:   e.res = &d;
      2'b10:   e.res = ^d;
      default: e.res = ~|d;
    endcase
    e.cnt = CNT_W'($countones(d));
    return e;
  endfunction

  // Called at a falling edge with the block idle; the accept happens on the next rising edge.
  task automatic send(input logic [WIDTH-1:0] d, input logic [1:0] op, input bit score);
    in_valid = 1'b1;
    in_data  = d;
    in_op    = op;
    if (score) sb.push_back(model(d, op));
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
    in_op    = 2'($urandom);
  endtask

  task automatic wait_valid(output int cyc, output int rdy_seen);
    cyc = 0;
    rdy_seen = 0;
    while (!out_valid && cyc < 64) begin
      if (in_ready) rdy_seen++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic release_out(input int hold);
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_op    = 2'b01;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_flags: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
      end
    end
    vectors++;
    if (out_result !== 1'b0 || out_count !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: result=%b count=%0d, required 0/0", out_result, out_count);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_no_capture: in_ready=%b, required 1", in_ready);
    end
    $display("reset: in_ready=%b out_valid=%b result=%b count=%0d", in_ready, out_valid, out_result, out_count);
  endtask

  task automatic test_ops;
    logic [WIDTH-1:0] dt[7] = '{8'h00, 8'h80, 8'h80, 8'hFF, 8'hFE, 8'hA5, 8'h07};
    logic [1:0]       ot[7] = '{2'b00, 2'b00, 2'b11, 2'b01, 2'b01, 2'b10, 2'b10};
    // Plain constants for the listed vectors, independent of the model.
    logic             rt[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int               ct[7] = '{0, 1, 1, 8, 7, 4, 3};
    int cyc, rdy;
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      send(dt[i], ot[i], 1'b1);
      wait_valid(cyc, rdy);
      e = sb.pop_front();
      vectors += 4;
      if (cyc !== WIDTH || rdy !== 0) begin
        miscompares++;
        $display("FAIL ops_latency[%0d]: cycles=%0d ready_in_busy=%0d, required %0d/0", i, cyc, rdy, WIDTH);
      end
      if (out_result !== e.res || out_count !== e.cnt) begin
        miscompares++;
        $display("FAIL ops_model[%0d]: result=%b count=%0d, required %b/%0d", i, out_result, out_count, e.res, e.cnt);
      end
      if (out_result !== rt[i]) begin
        miscompares++;
        $display("FAIL ops_result[%0d]: result=%b, required %b", i, out_result, rt[i]);
      end
      if (out_count !== CNT_W'(ct[i])) begin
        miscompares++;
        $display("FAIL ops_count[%0d]: count=%0d, required %0d", i, out_count, ct[i]);
      end
      $display("word %h op %0d -> result %b count %0d latency %0d", dt[i], ot[i], out_result, out_count, cyc);
      release_out(0);
    end
  endtask

  task automatic test_backpressure;
    int cyc, rdy;
    exp_t e;
    send(8'hA5, 2'b10, 1'b1);
    wait_valid(cyc, rdy);
    e = sb.pop_front();
    vectors++;
    if (cyc !== WIDTH) begin
      miscompares++;
      $display("FAIL bp_latency: cycles=%0d, required %0d", cyc, WIDTH);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      in_data  = WIDTH'($urandom);
      in_op    = 2'($urandom);
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== e.res || out_count !== e.cnt) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: valid=%b ready=%b result=%b count=%0d, required 1/0/%b/%0d",
                 i, out_valid, in_ready, out_result, out_count, e.res, e.cnt);
      end
    end
    in_valid = 1'b0;
    release_out(0);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== e.res || out_count !== e.cnt) begin
      miscompares++;
      $display("FAIL bp_release: ready=%b valid=%b result=%b count=%0d, required 1/0/%b/%0d",
               in_ready, out_valid, out_result, out_count, e.res, e.cnt);
    end
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_no_capture: in_ready=%b, required 1", in_ready);
    end
    $display("backpressure: word a5 xor held result %b count %0d", e.res, e.cnt);
  endtask

  task automatic test_reset_mid;
    int cyc, rdy;
    exp_t e;
    send(8'hFF, 2'b01, 1'b0);
    repeat (2) @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_busy: in_ready=%b, required 0", in_ready);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_async: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || out_result !== 1'b0 || out_count !== '0) begin
      miscompares++;
      $display("FAIL mid_cleared: valid=%b result=%b count=%0d, required 0/0/0", out_valid, out_result, out_count);
    end
    rst_n = 1'b1;
    send(8'h01, 2'b00, 1'b1);
    wait_valid(cyc, rdy);
    e = sb.pop_front();
    vectors++;
    if (cyc !== WIDTH || out_result !== 1'b1 || out_count !== CNT_W'(1) ||
        out_result !== e.res || out_count !== e.cnt) begin
      miscompares++;
      $display("FAIL mid_recover: cycles=%0d result=%b count=%0d, required %0d/1/1", cyc, out_result, out_count, WIDTH);
    end
    $display("reset mid-op: recovered word 01 or -> result %b count %0d", out_result, out_count);
    release_out(0);
  endtask

  task automatic test_back_to_back;
    int cyc, rdy;
    exp_t e;
    logic [WIDTH-1:0] d;
    logic [1:0] op;
    for (int i = 0; i < 20; i++) begin
      d  = WIDTH'($urandom);
      op = 2'($urandom);
      if (i == 0) d = 8'hFF;
      if (i == 1) d = 8'h01;
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_ready[%0d]: in_ready=%b, required 1", i, in_ready);
      end
      send(d, op, 1'b1);
      wait_valid(cyc, rdy);
      e = sb.pop_front();
      vectors++;
      if (cyc !== WIDTH || rdy !== 0 || out_result !== e.res || out_count !== e.cnt) begin
        miscompares++;
        $display("FAIL b2b[%0d]: cycles=%0d result=%b count=%0d, required %0d/%b/%0d",
                 i, cyc, out_result, out_count, WIDTH, e.res, e.cnt);
      end
      $display("word %h op %0d -> result %b count %0d latency %0d", d, op, out_result, out_count, cyc);
      release_out(int'($urandom_range(0, 3)));
    end
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset;
    test_ops;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_mux_reducer.md
Name: serial_mux_reducer

Overview:
Sequential bit-serial reduction stage that feeds the single-bit mux-built gate primitives in the combinational-logic set. It accepts a WIDTH-bit word over a valid/ready handshake and scans it LSB-first, one bit per cycle. Each step combines the running accumulator with the current bit through a 2:1 mux selection (for example, OR step = acc ? 1 : bit). It returns a one-bit reduction (OR/AND/XOR/NOR) plus a population count over a valid/ready output handshake.

Parameters:
WIDTH, 8, input word width in bits; legal range 2..64
CNT_W, $clog2(WIDTH+1), width of out_count; derived, not overridden

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  upstream has a word
in_ready  output  1  block can accept a word
in_data  input  WIDTH  word to reduce
in_op  input  2  00=OR, 01=AND, 10=XOR, 11=NOR
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out_result  output  1  reduction result
out_count  output  CNT_W  number of 1 bits in captured word

Behaviour:
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
  - in_ready and out_valid are decoded from state only; no combinational path from in_valid or out_ready.
- Reset (rst_n low, asynchronous):
  - state=IDLE, out_result=0, out_count=0, internal data/op/index/accumulator cleared.
  - in_ready reads 1 during reset, but no capture occurs while rst_n is low.
  - Deassertion is synchronised externally; the first capture can happen on the first rising edge with rst_n high.
- Accept (IDLE with in_valid=1 at a rising edge):
  - Latch in_data and in_op; set index=0 and count=0.
  - Accumulator starts at the op identity: 0 for OR/XOR/NOR, 1 for AND.
  - Go to BUSY.
- BUSY, each edge, with b = data[index]:
  - OR/NOR: acc = acc ? 1 : b
  - AND: acc = acc ? b : 0
  - XOR: acc = b ? ~acc : acc
  - count += b; index += 1.
  - On the edge where index==WIDTH-1 is processed, go to DONE.
- DONE:
  - out_result = acc for OR/AND/XOR, ~acc for NOR; out_count = count.
  - Both are registered and held stable for the whole time out_valid=1.
- Latency:
  - Word accepted at edge k gives out_valid=1 after edge k+WIDTH. This is fixed; no early termination for any op or data value.
- Output handshake:
  - out_valid && out_ready at an edge → IDLE.
  - out_result and out_count keep their last values after leaving DONE (not cleared).
  - Throughput is one word per WIDTH+2 cycles; there is no same-cycle pass-through from DONE to a new accept.
- in_valid in BUSY/DONE is ignored; in_data/in_op changes after capture have no effect.
- out_ready in IDLE/BUSY is ignored.
- Backpressure: DONE is held indefinitely while out_ready=0.
- Reset asserted in any state aborts the operation immediately; the partial result is discarded and never presented.
- out_count never exceeds WIDTH; the counter is sized CNT_W so there is no wrap.

Test Plan:
1. WIDTH=8. Reset, then accept in_data=8'h00, op=OR → out_valid rises exactly 8 edges after the accept edge; out_result=0, out_count=0; in_ready=0 throughout BUSY.
2. in_data=8'h80, op=OR (only the last-scanned bit set) → out_result=1, out_count=1. Then 8'h80 with op=NOR → out_result=0.
3. in_data=8'hFF, op=AND → out_result=1, out_count=8. Then 8'hFE, op=AND → out_result=0, out_count=7.
4. in_data=8'hA5, op=XOR → out_result=0, out_count=4. Then 8'h07, op=XOR → out_result=1, out_count=3.
5. Backpressure:
   - Stimulus: hold out_ready=0 for 5 cycles after out_valid, toggling in_valid and in_data meanwhile.
   - Required: out_valid, out_result and out_count stay stable; in_ready=0; the new word is not captured.
   - Then: raise out_ready; in_ready=1 on the next cycle.
6. Reset mid-operation:
   - Stimulus: pull rst_n low 3 cycles into BUSY for 8'hFF/AND.
   - Required: state returns to IDLE and out_valid stays 0 immediately, without waiting for a clock edge.
   - Then: after release, 8'h01/OR → out_result=1, out_count=1.
